// File: rtl/vga_scan_controller.sv
// VGA raster timing for the pong display: scan counters, registered sync,
// blanked pixel output and a once-per-frame tick at the start of vertical blanking.
module vga_scan_controller #(
   parameter int   H_ACTIVE          = 640,
   parameter int   H_FRONT           = 16,
   parameter int   H_SYNC            = 96,
   parameter int   H_BACK            = 48,
   parameter int   V_ACTIVE          = 480,
   parameter int   V_FRONT           = 10,
   parameter int   V_SYNC            = 2,
   parameter int   V_BACK            = 33,
   parameter logic SYNC_ACTIVE_LEVEL = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pixelEn,
   input  logic [7:0]  pixelIn,
   output logic [15:0] nextX,
   output logic [15:0] nextY,
   output logic        hsync,
   output logic        vsync,
   output logic [7:0]  pixelOut,
   output logic        displayActive,
   output logic        frameTick
);

   localparam logic [15:0] H_LAST   = 16'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [15:0] V_LAST   = 16'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [15:0] H_ACT    = 16'(H_ACTIVE);
   localparam logic [15:0] V_ACT    = 16'(V_ACTIVE);
   localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FRONT);
   localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FRONT);
   localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FRONT + V_SYNC);

   logic [15:0] hCount_q, hCount_d;
   logic [15:0] vCount_q, vCount_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic [7:0]  pixel_q, pixel_d;
   logic        active_q, active_d;
   logic        tick_q, tick_d;

   always_comb begin
      hCount_d = hCount_q + 16'd1;
      vCount_d = vCount_q;
      if (hCount_q == H_LAST) begin
         hCount_d = 16'd0;
         vCount_d = (vCount_q == V_LAST) ? 16'd0 : vCount_q + 16'd1;
      end
   end

   // Output stage decodes the counters as they stand before this edge.
   always_comb begin
      active_d = (hCount_q < H_ACT) && (vCount_q < V_ACT);
      hsync_d  = ((hCount_q >= HS_START) && (hCount_q < HS_END)) ?
                 SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
      vsync_d  = ((vCount_q >= VS_START) && (vCount_q < VS_END)) ?
                 SYNC_ACTIVE_LEVEL : ~SYNC_ACTIVE_LEVEL;
      pixel_d  = active_d ? pixelIn : 8'h00;
      tick_d   = (hCount_q == 16'd0) && (vCount_q == V_ACT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hCount_q <= 16'd0;
         vCount_q <= 16'd0;
         hsync_q  <= ~SYNC_ACTIVE_LEVEL;
         vsync_q  <= ~SYNC_ACTIVE_LEVEL;
         pixel_q  <= 8'h00;
         active_q <= 1'b0;
         tick_q   <= 1'b0;
      end else if (pixelEn) begin
         hCount_q <= hCount_d;
         vCount_q <= vCount_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         pixel_q  <= pixel_d;
         active_q <= active_d;
         tick_q   <= tick_d;
      end
   end

   assign nextX         = hCount_q;
   assign nextY         = vCount_q;
   assign hsync         = hsync_q;
   assign vsync         = vsync_q;
   assign pixelOut      = pixel_q;
   assign displayActive = active_q;
   assign frameTick     = tick_q;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Bench for vga_scan_controller using a reduced raster so whole frames fit in a short run;
// expectations come from a position-in-frame model of the scan.
module tb_vga_scan_controller;

   localparam int HA = 20, HF = 3, HS = 5, HB = 4;
   localparam int VA = 6, VF = 2, VS = 2, VB = 3;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam logic SAL = 1'b0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        pixelEn;
   logic [7:0]  pixelIn;
   logic [15:0] nextX, nextY;
   logic        hsync, vsync, displayActive, frameTick;
   logic [7:0]  pixelOut;

   int checks = 0;
   int errors = 0;

   int         p;
   logic       eh, ev, eact, etick;
   logic [7:0] epix;

   vga_scan_controller #(
      .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .SYNC_ACTIVE_LEVEL(SAL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pixelEn(pixelEn), .pixelIn(pixelIn),
      .nextX(nextX), .nextY(nextY), .hsync(hsync), .vsync(vsync),
      .pixelOut(pixelOut), .displayActive(displayActive), .frameTick(frameTick)
   );

   always #5 clk = ~clk;

   function automatic logic [43:0] got();
      return {nextX, nextY, hsync, vsync, pixelOut, displayActive, frameTick};
   endfunction

   function automatic logic [43:0] expv();
      return {16'(p % HT), 16'(p / HT), eh, ev, epix, eact, etick};
   endfunction

   task automatic model_reset();
      p = 0; eh = ~SAL; ev = ~SAL; epix = 8'h00; eact = 1'b0; etick = 1'b0;
   endtask

   // Drive one clock at posedge+1; the model advances its frame position
   // only on enabled edges and publishes what the pins should show afterwards.
   task automatic step(input logic en, input logic [7:0] pix);
      int x, y;
      logic act;
      pixelEn = en;
      pixelIn = pix;
      if (en) begin
         x = p % HT;
         y = p / HT;
         act   = (x < HA) && (y < VA);
         eh    = (x >= HA + HF && x < HA + HF + HS) ? SAL : ~SAL;
         ev    = (y >= VA + VF && y < VA + VF + VS) ? SAL : ~SAL;
         epix  = act ? pix : 8'h00;
         eact  = act;
         etick = (x == 0) && (y == VA);
         p = (p + 1) % FT;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; pixelEn = 1'b1; pixelIn = 8'hFF;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (got() !== expv()) begin
         errors++;
         $display("FAIL reset_hold got=%h exp=%h", got(), expv());
      end
      rst_n = 1'b1;
      for (int i = 0; i < 40; i++) step(1'b1, 8'(i + 1));
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (got() !== expv()) begin
         errors++;
         $display("FAIL reset_async got=%h exp=%h", got(), expv());
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic test_frame();
      int hs_n = 0, vs_n = 0, act_n = 0, tk_n = 0;
      for (int i = 0; i < FT; i++) begin
         step(1'b1, 8'($urandom_range(1, 255)));
         checks++;
         if (got() !== expv()) begin
            errors++;
            if (errors < 20) $display("FAIL frame i=%0d got=%h exp=%h", i, got(), expv());
         end
         hs_n  += (hsync == SAL);
         vs_n  += (vsync == SAL);
         act_n += displayActive;
         tk_n  += frameTick;
      end
      checks++;
      if (hs_n !== HS * VT || vs_n !== VS * HT || act_n !== HA * VA || tk_n !== 1) begin
         errors++;
         $display("FAIL frame_counts hs=%0d vs=%0d act=%0d tick=%0d exp %0d %0d %0d 1",
                  hs_n, vs_n, act_n, tk_n, HS * VT, VS * HT, HA * VA);
      end
   endtask

   task automatic test_blanking();
      int leak = 0;
      for (int i = 0; i < FT; i++) begin
         step(1'b1, nextX[7:0] ^ 8'h5A);
         checks++;
         if (got() !== expv()) begin
            errors++;
            if (errors < 20) $display("FAIL blanking i=%0d got=%h exp=%h", i, got(), expv());
         end
         if (!displayActive && pixelOut !== 8'h00) leak++;
      end
      checks++;
      if (leak != 0) begin
         errors++;
         $display("FAIL blank_leak got=%0d exp=0", leak);
      end
   endtask

   task automatic test_pixel_en();
      int tk_clk = 0, act_clk = 0;
      for (int i = 0; i < 2 * FT; i++) begin
         step(1'(i % 2 == 0), 8'($urandom));
         checks++;
         if (got() !== expv()) begin
            errors++;
            if (errors < 20) $display("FAIL pixel_en i=%0d got=%h exp=%h", i, got(), expv());
         end
         tk_clk  += frameTick;
         act_clk += displayActive;
      end
      checks++;
      if (tk_clk !== 2 || act_clk !== 2 * HA * VA) begin
         errors++;
         $display("FAIL pixel_en_span tick=%0d act=%0d exp 2 %0d", tk_clk, act_clk, 2 * HA * VA);
      end
   endtask

   task automatic test_random_en();
      for (int i = 0; i < 3 * FT; i++) begin
         step(1'($urandom_range(0, 2) != 0), 8'($urandom));
         checks++;
         if (got() !== expv()) begin
            errors++;
            if (errors < 20) $display("FAIL random_en i=%0d got=%h exp=%h", i, got(), expv());
         end
      end
   endtask

   task automatic test_mid_reset();
      int target = (VA / 2) * HT + HA + HF + 1;
      int act_n = 0;
      for (int i = 0; i < FT && p != target; i++) step(1'b1, 8'h33);
      checks++;
      if (hsync !== SAL || got() !== expv()) begin
         errors++;
         $display("FAIL mid_pre hsync=%b got=%h exp=%h", hsync, got(), expv());
      end
      #3 rst_n = 1'b0;
      model_reset();
      #1;
      checks++;
      if (hsync !== ~SAL || got() !== expv()) begin
         errors++;
         $display("FAIL mid_reset hsync=%b got=%h exp=%h", hsync, got(), expv());
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < HT; i++) begin
         step(1'b1, 8'($urandom));
         checks++;
         if (got() !== expv()) begin
            errors++;
            if (errors < 20) $display("FAIL mid_after i=%0d got=%h exp=%h", i, got(), expv());
         end
         if (i == 0 && displayActive !== 1'b1) begin
            errors++;
            $display("FAIL mid_first_active got=%b exp=1", displayActive);
         end
         act_n += displayActive;
      end
      checks++;
      if (act_n !== HA) begin
         errors++;
         $display("FAIL mid_line_active got=%0d exp=%0d", act_n, HA);
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_blanking();
      test_pixel_en();
      test_random_en();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
